// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern-memory game controller.
package led_pattern_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    INPUT,
    PASS,
    FAIL,
    WIN
  } state_t;

  // Feedback taps q[7], q[5], q[4], q[3]
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // Widest pattern index supported (LED_W up to 8)
  localparam int unsigned MAX_IDX_W = 3;

  // One-hot decode of a pattern index; callers truncate to LED_W
  function automatic logic [7:0] onehot(input logic [MAX_IDX_W-1:0] index);
    onehot = 8'd1 << index;
  endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// 8-bit Fibonacci LFSR producing pattern entries from its low bits.
module pattern_lfsr
  import led_pattern_pkg::*;
#(
  parameter int unsigned OUT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             advance,
  input  logic [7:0]       seed,
  output logic [OUT_W-1:0] entry
);

  logic [7:0] q;

  // Load (zero seed replaced by the default), else shift left on advance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= DEFAULT_SEED;
    end else if (load) begin
      q <= (seed == 8'd0) ? DEFAULT_SEED : seed;
    end else if (advance) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

  // Entry is the pre-shift value of the current register
  assign entry = q[OUT_W-1:0];

endmodule

// File: rtl/led_pattern_ctrl.sv
// Sequencer for the LED pattern-memory game: generate, show, check, score.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int unsigned LED_W         = 4,
  parameter int unsigned MAX_LEN       = 10,
  parameter int unsigned ON_TICKS      = 4,
  parameter int unsigned OFF_TICKS     = 2,
  parameter int unsigned INPUT_TIMEOUT = 40,
  parameter int unsigned RESULT_TICKS  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic             tick,
  input  logic [LED_W-1:0] btn,
  output logic [LED_W-1:0] led,
  output logic             accept_input,
  output logic             busy,
  output logic [3:0]       level,
  output logic [3:0]       step,
  output logic             pass,
  output logic             fail,
  output logic             win
);

  localparam int unsigned IDX_W = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [3:0]       LAST_GEN     = 4'(MAX_LEN - 1);
  localparam logic [3:0]       MAX_LEVEL    = 4'(MAX_LEN);
  localparam logic [CNT_W-1:0] ON_LAST      = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INPUT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RESULT_LAST  = CNT_W'(RESULT_TICKS - 1);

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [3:0]       gen_idx;
  logic [IDX_W-1:0] mem [MAX_LEN];

  logic [IDX_W-1:0] lfsr_entry;
  logic [IDX_W-1:0] first_entry;
  logic             start_ok;
  logic             step_last;
  logic [LED_W-1:0] expect_btn;
  logic [LED_W-1:0] first_led;
  logic [LED_W-1:0] next_led;

  // Start is only honoured while no game is in progress
  assign start_ok  = start && ((state == IDLE) || (state == WIN));
  assign step_last = (step == (level - 4'd1));

  pattern_lfsr #(
    .OUT_W (IDX_W)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start_ok),
    .advance (state == GEN),
    .seed    (seed),
    .entry   (lfsr_entry)
  );

  // Entry 0 is still in flight on the last GEN cycle only when MAX_LEN is 1
  assign first_entry = (gen_idx == 4'd0) ? lfsr_entry : mem[0];
  assign first_led   = LED_W'(onehot(MAX_IDX_W'(first_entry)));
  assign next_led    = LED_W'(onehot(MAX_IDX_W'(mem[step + 4'd1])));
  assign expect_btn  = LED_W'(onehot(MAX_IDX_W'(mem[step])));

  // Pattern memory fill, one entry per clock during GEN
  always_ff @(posedge clk) begin
    if (state == GEN) begin
      mem[gen_idx] <= lfsr_entry;
    end
  end

  // Game FSM; every transition also sets the registered outputs of its target
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      gen_idx      <= '0;
      level        <= '0;
      step         <= '0;
      led          <= '0;
      accept_input <= 1'b0;
      busy         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      win          <= 1'b0;
    end else begin
      case (state)
        IDLE, WIN: begin
          if (start_ok) begin
            state    <= GEN;
            tick_cnt <= '0;
            gen_idx  <= '0;
            level    <= 4'd1;
            step     <= '0;
            busy     <= 1'b1;
            win      <= 1'b0;
          end
        end

        GEN: begin
          if (gen_idx == LAST_GEN) begin
            state    <= SHOW_ON;
            tick_cnt <= '0;
            step     <= '0;
            led      <= first_led;
          end else begin
            gen_idx <= gen_idx + 4'd1;
          end
        end

        SHOW_ON: begin
          if (tick) begin
            if (tick_cnt == ON_LAST) begin
              state    <= SHOW_OFF;
              tick_cnt <= '0;
              led      <= '0;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        SHOW_OFF: begin
          if (tick) begin
            if (tick_cnt == OFF_LAST) begin
              tick_cnt <= '0;
              if (step_last) begin
                state        <= INPUT;
                step         <= '0;
                accept_input <= 1'b1;
              end else begin
                state <= SHOW_ON;
                step  <= step + 4'd1;
                led   <= next_led;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        INPUT: begin
          if (btn != '0) begin
            // A press always wins over a coincident tick and restarts the timeout
            tick_cnt <= '0;
            if (btn != expect_btn) begin
              state        <= FAIL;
              accept_input <= 1'b0;
              fail         <= 1'b1;
            end else if (step_last) begin
              state        <= PASS;
              accept_input <= 1'b0;
              pass         <= 1'b1;
            end else begin
              step <= step + 4'd1;
            end
          end else if (tick) begin
            if (tick_cnt == TIMEOUT_LAST) begin
              state        <= FAIL;
              tick_cnt     <= '0;
              accept_input <= 1'b0;
              fail         <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        PASS: begin
          if (tick) begin
            if (tick_cnt == RESULT_LAST) begin
              tick_cnt <= '0;
              pass     <= 1'b0;
              if (level == MAX_LEVEL) begin
                state <= WIN;
                busy  <= 1'b0;
                win   <= 1'b1;
              end else begin
                // Same pattern, one step longer
                state <= SHOW_ON;
                level <= level + 4'd1;
                step  <= '0;
                led   <= LED_W'(onehot(MAX_IDX_W'(mem[0])));
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        FAIL: begin
          if (tick) begin
            if (tick_cnt == RESULT_LAST) begin
              state    <= IDLE;
              tick_cnt <= '0;
              fail     <= 1'b0;
              busy     <= 1'b0;
              level    <= '0;
              step     <= '0;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with a pattern-level game model.
module tb_led_pattern_ctrl;

  localparam int unsigned LED_W         = 4;
  localparam int unsigned MAX_LEN       = 10;
  localparam int unsigned ON_TICKS      = 4;
  localparam int unsigned OFF_TICKS     = 2;
  localparam int unsigned INPUT_TIMEOUT = 40;
  localparam int unsigned RESULT_TICKS  = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [7:0]       seed;
  logic             tick;
  logic [LED_W-1:0] btn;
  logic [LED_W-1:0] led;
  logic             accept_input;
  logic             busy;
  logic [3:0]       level;
  logic [3:0]       step;
  logic             pass;
  logic             fail;
  logic             win;

  int errors = 0;
  int checks = 0;
  int tick_pct = 60;
  int pat [MAX_LEN];

  led_pattern_ctrl #(
    .LED_W         (LED_W),
    .MAX_LEN       (MAX_LEN),
    .ON_TICKS      (ON_TICKS),
    .OFF_TICKS     (OFF_TICKS),
    .INPUT_TIMEOUT (INPUT_TIMEOUT),
    .RESULT_TICKS  (RESULT_TICKS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .seed         (seed),
    .tick         (tick),
    .btn          (btn),
    .led          (led),
    .accept_input (accept_input),
    .busy         (busy),
    .level        (level),
    .step         (step),
    .pass         (pass),
    .fail         (fail),
    .win          (win)
  );

  always #5 clk = ~clk;

  // Reference pattern: the game's LFSR rule applied step by step
  function automatic void make_pattern(input logic [7:0] sd);
    logic [7:0] q;
    q = (sd == 8'd0) ? 8'hA5 : sd;
    for (int i = 0; i < MAX_LEN; i++) begin
      pat[i] = int'(q) % LED_W;
      q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  endfunction

  function automatic logic [LED_W-1:0] oh(input int idx);
    logic [LED_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic rnd_tick();
    return ($urandom_range(0, 99) < tick_pct);
  endfunction

  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0; seed = 8'd0; tick = 1'b0; btn = '0;
    step_clk();
    step_clk();
    reset_n = 1'b1;
    step_clk();
  endtask

  task automatic start_game(input logic [7:0] sd);
    make_pattern(sd);
    start = 1'b1;
    seed  = sd;
    tick  = rnd_tick();
    step_clk();
    start = 1'b0;
    tick  = 1'b0;
  endtask

  // Counts cycles spent generating (busy, dark) before the first LED lights
  task automatic wait_gen(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && led === '0 && cyc < 100) begin
      tick = rnd_tick();
      step_clk();
      cyc++;
    end
    tick = 1'b0;
  endtask

  // Watches a full show of lvl steps; returns cycles that disagree with the pattern
  task automatic run_show(input int lvl, input bit noise, output int errs);
    int n, guard, need;
    logic [LED_W-1:0] exp_led;
    errs = 0;
    for (int s = 0; s < lvl; s++) begin
      for (int ph = 0; ph < 2; ph++) begin
        n = 0; guard = 0;
        need = (ph == 0) ? ON_TICKS : OFF_TICKS;
        exp_led = (ph == 0) ? oh(pat[s]) : LED_W'(0);
        while (n < need) begin
          if (led !== exp_led || busy !== 1'b1 || accept_input !== 1'b0 ||
              level !== 4'(lvl) || step !== 4'(s)) errs++;
          tick = rnd_tick();
          if (noise) begin
            start = 1'($urandom_range(0, 1));
            seed  = 8'($urandom);
            btn   = LED_W'($urandom);
          end
          step_clk();
          if (tick) n++;
          guard++;
          if (guard > 500) begin errs++; break; end
        end
      end
    end
    tick = 1'b0; start = 1'b0; btn = '0;
  endtask

  // Plays back the pattern for a round with short random gaps
  task automatic answer_round(input int lvl, output int errs);
    errs = 0;
    for (int s = 0; s < lvl; s++) begin
      repeat ($urandom_range(0, 3)) begin
        if (accept_input !== 1'b1 || step !== 4'(s)) errs++;
        tick = rnd_tick();
        step_clk();
      end
      if (accept_input !== 1'b1) errs++;
      btn  = oh(pat[s]);
      tick = rnd_tick();
      step_clk();
      btn  = '0;
      tick = 1'b0;
      if (s < lvl - 1) begin
        if (accept_input !== 1'b1 || pass !== 1'b0) errs++;
      end else begin
        if (pass !== 1'b1 || accept_input !== 1'b0) errs++;
      end
    end
  endtask

  // Counts ticks delivered while the pass (or fail) indication is high
  task automatic hold_result(input bit is_pass, output int ticks);
    int guard;
    ticks = 0; guard = 0;
    while (((is_pass ? pass : fail) === 1'b1) && guard < 2000) begin
      tick = rnd_tick();
      step_clk();
      if (tick) ticks++;
      guard++;
    end
    tick = 1'b0;
  endtask

  // Starts a game and answers rounds below target; ends at the target's first lit step
  task automatic play_to_show(input int target, output int errs);
    int e, t, gc;
    errs = 0;
    start_game(8'($urandom));
    wait_gen(gc);
    if (gc != MAX_LEN) errs++;
    for (int l = 1; l < target; l++) begin
      run_show(l, 1'b0, e);   errs += e;
      answer_round(l, e);     errs += e;
      hold_result(1'b1, t);
      if (t != RESULT_TICKS) errs++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({led, accept_input, busy, level, step, pass, fail, win} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got led=%b acc=%b busy=%b lvl=%0d step=%0d p=%b f=%b w=%b, expected all zero",
               led, accept_input, busy, level, step, pass, fail, win);
    end
  endtask

  task automatic test_gen_show();
    int gc, e;
    do_reset();
    tick_pct = 100;
    start_game(8'h00);
    wait_gen(gc);
    checks++;
    if (gc != MAX_LEN) begin
      errors++;
      $display("FAIL gen_cycles: got %0d expected %0d", gc, MAX_LEN);
    end
    run_show(1, 1'b0, e);
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL show_level1_seed0: %0d bad cycles, expected 0", e);
    end
    checks++;
    if (accept_input !== 1'b1 || level !== 4'd1 || led !== '0) begin
      errors++;
      $display("FAIL input_entry: got acc=%b level=%0d led=%b, expected acc=1 level=1 led=0",
               accept_input, level, led);
    end
    tick_pct = 60;
  endtask

  task automatic test_full_game();
    int e, t, gc, bad;
    do_reset();
    start_game(8'($urandom));
    wait_gen(gc);
    for (int l = 1; l <= MAX_LEN; l++) begin
      run_show(l, 1'b0, e);
      checks++;
      if (e != 0 || level !== 4'(l) || accept_input !== 1'b1) begin
        errors++;
        $display("FAIL game_show_l%0d: bad=%0d level=%0d acc=%b, expected bad=0 level=%0d acc=1",
                 l, e, level, accept_input, l);
      end
      answer_round(l, e);
      hold_result(1'b1, t);
      checks++;
      if (e != 0 || t != RESULT_TICKS) begin
        errors++;
        $display("FAIL game_pass_l%0d: answer_bad=%0d pass_ticks=%0d, expected 0 and %0d",
                 l, e, t, RESULT_TICKS);
      end
    end
    checks++;
    if (win !== 1'b1 || level !== 4'(MAX_LEN) || busy !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL win_entry: got win=%b level=%0d busy=%b pass=%b, expected 1 %0d 0 0",
               win, level, busy, pass, MAX_LEN);
    end
    bad = 0;
    repeat (20) begin
      tick = rnd_tick();
      btn  = LED_W'($urandom);
      step_clk();
      if (win !== 1'b1 || level !== 4'(MAX_LEN) || busy !== 1'b0) bad++;
    end
    btn = '0; tick = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL win_hold: %0d cycles left WIN, expected 0", bad);
    end
    start_game(8'($urandom));
    checks++;
    if (level !== 4'd1 || busy !== 1'b1 || win !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_win: got level=%0d busy=%b win=%b, expected 1 1 0", level, busy, win);
    end
    wait_gen(gc);
    run_show(1, 1'b0, e);
    checks++;
    if (gc != MAX_LEN || e != 0) begin
      errors++;
      $display("FAIL restart_show: gen=%0d bad=%0d, expected %0d and 0", gc, e, MAX_LEN);
    end
  endtask

  task automatic test_reset_midround();
    int e, bad;
    do_reset();
    play_to_show(3, e);
    checks++;
    if (e != 0 || level !== 4'd3 || led !== oh(pat[0])) begin
      errors++;
      $display("FAIL reach_level3: bad=%0d level=%0d led=%b, expected 0 3 %b", e, level, led, oh(pat[0]));
    end
    reset_n = 1'b0;
    tick = 1'b1;
    step_clk();
    checks++;
    if (led !== '0 || level !== 4'd0 || busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL midround_reset: got led=%b level=%0d busy=%b pass=%b fail=%b, expected all 0",
               led, level, busy, pass, fail);
    end
    step_clk();
    reset_n = 1'b1;
    bad = 0;
    repeat (10) begin
      tick = rnd_tick();
      step_clk();
      if (busy !== 1'b0 || level !== 4'd0 || led !== '0 || pass !== 1'b0 || fail !== 1'b0) bad++;
    end
    tick = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_reset: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_wrong_button();
    int e, t;
    logic [LED_W-1:0] wrong;
    do_reset();
    play_to_show(3, e);
    run_show(3, 1'b0, e);
    btn = oh(pat[0]);
    step_clk();
    btn = '0;
    checks++;
    if (accept_input !== 1'b1 || step !== 4'd1) begin
      errors++;
      $display("FAIL first_correct: got acc=%b step=%0d, expected acc=1 step=1", accept_input, step);
    end
    wrong = oh((pat[1] + 1 + int'($urandom_range(0, LED_W - 2))) % LED_W);
    btn = wrong;
    step_clk();
    btn = '0;
    checks++;
    if (accept_input !== 1'b0 || fail !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL wrong_press: got acc=%b fail=%b pass=%b, expected 0 1 0", accept_input, fail, pass);
    end
    hold_result(1'b0, t);
    checks++;
    if (t != RESULT_TICKS || level !== 4'd0 || busy !== 1'b0 || led !== '0) begin
      errors++;
      $display("FAIL fail_hold: ticks=%0d level=%0d busy=%b led=%b, expected %0d 0 0 0",
               t, level, busy, led, RESULT_TICKS);
    end
  endtask

  task automatic test_timeout();
    int e, t;
    do_reset();
    play_to_show(1, e);
    run_show(1, 1'b0, e);
    tick = 1'b1;
    repeat (INPUT_TIMEOUT - 1) step_clk();
    checks++;
    if (accept_input !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL before_timeout: got acc=%b fail=%b, expected 1 0", accept_input, fail);
    end
    step_clk();
    tick = 1'b0;
    checks++;
    if (fail !== 1'b1 || accept_input !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got fail=%b acc=%b, expected 1 0", fail, accept_input);
    end
    hold_result(1'b0, t);
    play_to_show(2, e);
    run_show(2, 1'b0, e);
    tick = 1'b1;
    repeat (INPUT_TIMEOUT - 1) step_clk();
    btn = oh(pat[0]);
    step_clk();
    btn = '0;
    checks++;
    if (accept_input !== 1'b1 || step !== 4'd1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL press_at_39: got acc=%b step=%0d fail=%b, expected 1 1 0", accept_input, step, fail);
    end
    repeat (INPUT_TIMEOUT - 1) step_clk();
    tick = 1'b0;
    checks++;
    if (accept_input !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL restart_timeout: got acc=%b fail=%b, expected 1 0", accept_input, fail);
    end
    btn = oh(pat[1]);
    step_clk();
    btn = '0;
    checks++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL late_pass: got pass=%b, expected 1", pass);
    end
    hold_result(1'b1, t);
  endtask

  task automatic test_multi_and_ignored();
    int e, t;
    do_reset();
    play_to_show(1, e);
    run_show(1, 1'b0, e);
    btn = 4'b0011;
    step_clk();
    btn = '0;
    checks++;
    if (fail !== 1'b1 || accept_input !== 1'b0) begin
      errors++;
      $display("FAIL multi_bit_press: got fail=%b acc=%b, expected 1 0", fail, accept_input);
    end
    hold_result(1'b0, t);
    play_to_show(1, e);
    run_show(1, 1'b1, e);
    checks++;
    if (e != 0 || accept_input !== 1'b1 || level !== 4'd1) begin
      errors++;
      $display("FAIL noisy_show: bad=%0d acc=%b level=%0d, expected 0 1 1", e, accept_input, level);
    end
    answer_round(1, e);
    hold_result(1'b1, t);
    checks++;
    if (e != 0 || t != RESULT_TICKS) begin
      errors++;
      $display("FAIL pattern_kept: answer_bad=%0d pass_ticks=%0d, expected 0 and %0d", e, t, RESULT_TICKS);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; seed = 8'd0; tick = 1'b0; btn = '0;
    test_reset();
    test_gen_show();
    test_full_game();
    test_reset_midround();
    test_wrong_button();
    test_timeout();
    test_multi_and_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
